// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master.
// Mode 0 link, active-high chip select.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } state_t;

  localparam int   DEF_DATA_W = 8;
  localparam logic CPOL       = 1'b0;
  localparam logic CPHA       = 1'b0;
  localparam logic CS_ACTIVE  = 1'b1;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period strobe: one-cycle tick every CLK_DIV
// cycles while en is high, counter held at 0 otherwise.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);

  if (CLK_DIV < 2) begin : g_chk
    $error("spi_tick_gen: CLK_DIV must be >= 2");
  end

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == TOP);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (!en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// Byte-wide mode-0 SPI master: MSB first, registered
// SCLK/MOSI/CS, MISO captured on each falling edge.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              BUSY,
  output logic              SCLK,
  output logic              MOSI,
  output logic              CS,
  input  logic              MISO
);

  localparam int EW = $clog2(2 * DATA_W) + 1;
  localparam logic [EW-1:0] LAST = EW'(2 * DATA_W);
  localparam logic [EW-1:0] LFALL = EW'(2 * DATA_W - 1);

  state_t            state_q, state_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rxd_q, rxd_d;
  logic              rxv_q, rxv_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_q, cs_d;
  logic [1:0]        sync_q;
  logic              tick;
  logic              accept;
  logic              smp;

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .CLK  (CLK),
    .RST_N(RST_N),
    .en   (state_q != IDLE),
    .tick (tick)
  );

  // Release of RST_N is only trusted two edges later.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign accept = TX_VALID && TX_READY && sync_q[1];
  assign smp    = ((sclk_q == CPOL) == CPHA);

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxd_d   = rxd_q;
    rxv_d   = 1'b0;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          cs_d    = CS_ACTIVE;
          tx_d    = TX_DATA;
          mosi_d  = TX_DATA[DATA_W-1];
          rx_d    = '0;
          edge_d  = '0;
          sclk_d  = CPOL;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = XFER;
          sclk_d  = ~CPOL;
          edge_d  = EW'(1);
        end
      end
      XFER: begin
        if (tick) begin
          if (edge_q == LAST) begin
            state_d = HOLD;
          end else begin
            sclk_d = ~sclk_q;
            edge_d = edge_q + EW'(1);
            if (smp) begin
              rx_d = {rx_q[DATA_W-2:0], MISO};
              // the final fall leaves the LSB on MOSI
              if (edge_q != LFALL) begin
                tx_d   = tx_q << 1;
                mosi_d = tx_q[DATA_W-2];
              end
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = IDLE;
          cs_d    = ~CS_ACTIVE;
          rxd_d   = rx_q;
          rxv_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxd_q   <= '0;
      rxv_q   <= 1'b0;
      sclk_q  <= CPOL;
      mosi_q  <= 1'b0;
      cs_q    <= ~CS_ACTIVE;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxd_q   <= rxd_d;
      rxv_q   <= rxv_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
    end
  end

  assign TX_READY = (state_q == IDLE);
  assign BUSY     = (state_q != IDLE);
  assign RX_DATA  = rxd_q;
  assign RX_VALID = rxv_q;
  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;
  assign CS       = cs_q;

endmodule
